// File: rtl/alu_op_scheduler_if.sv
// rtl/alu_op_scheduler_if.sv - requester-side request/response bundle for alu_op_scheduler
interface alu_op_scheduler_if #(
  parameter int DATA_WIDTH = 512
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [2:0]            req_opcode0;
  logic [2:0]            req_opcode1;
  logic [DATA_WIDTH-1:0] req_data0;
  logic [DATA_WIDTH-1:0] req_data1;
  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_opcode0, req_opcode1, req_data0, req_data1,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_opcode0, req_opcode1, req_data0, req_data1,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - two-requester round-robin scheduler for a shared fixed-latency ALU
// Optional statistics counters enabled by defining ALU_SCHED_STATS_EN.
module alu_op_scheduler #(
  parameter int DATA_WIDTH  = 512,
  parameter int ALU_LATENCY = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_op_scheduler_if.slave     bus,
  output logic                  alu_issue,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_data,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  flush_req,
  output logic                  flush_done
`ifdef ALU_SCHED_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  stat_grant0,
  output logic [CNT_WIDTH-1:0]  stat_grant1,
  output logic [CNT_WIDTH-1:0]  stat_illegal
`endif
);

  localparam int CW = $clog2(ALU_LATENCY + 2) + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_FLUSHED
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    ptr_q;
  logic [1:0]              grant;
  logic [1:0]              xfer;
  logic                    accept_en;
  logic                    issue_owner_q;
  logic [ALU_LATENCY-1:0]  tag_v;
  logic [ALU_LATENCY-1:0]  tag_own;
  logic [ALU_LATENCY-1:0]  tag_ill;
  logic                    tag_out_v;
  logic [CW-1:0]           inflight_q;
  logic [1:0]              rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_err_q;

  // Pointer names the preferred requester when both are valid.
  always_comb begin
    grant = 2'b00;
    if (bus.req_valid[0] && (!bus.req_valid[1] || !ptr_q)) begin
      grant[0] = 1'b1;
    end else if (bus.req_valid[1]) begin
      grant[1] = 1'b1;
    end
  end

  assign accept_en     = (state_q == ST_RUN) && !flush_req && !rst;
  assign bus.req_ready = accept_en ? grant : 2'b00;
  assign xfer          = bus.req_ready & bus.req_valid;
  assign tag_out_v     = tag_v[ALU_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = ST_FLUSHED;
        end
      end
      ST_FLUSHED: begin
        flush_done = 1'b1;
        if (!flush_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= 1'b0;
      alu_issue     <= 1'b0;
      alu_opcode    <= 3'd0;
      alu_data      <= '0;
      issue_owner_q <= 1'b0;
    end else begin
      alu_issue <= |xfer;
      if (|xfer) begin
        ptr_q         <= xfer[0];
        issue_owner_q <= xfer[1];
        alu_opcode    <= xfer[1] ? bus.req_opcode1 : bus.req_opcode0;
        alu_data      <= xfer[1] ? bus.req_data1 : bus.req_data0;
      end
    end
  end

  // Tag stage k tracks the op issued k+1 edges ago; the last stage lines up with alu_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v   <= '0;
      tag_own <= '0;
      tag_ill <= '0;
    end else begin
      tag_v[0]   <= alu_issue;
      tag_own[0] <= issue_owner_q;
      tag_ill[0] <= alu_opcode[2];
      for (int i = 1; i < ALU_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_own[i] <= tag_own[i-1];
        tag_ill[i] <= tag_ill[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      if (tag_out_v) begin
        rsp_valid_q <= tag_own[ALU_LATENCY-1] ? 2'b10 : 2'b01;
        rsp_err_q   <= tag_ill[ALU_LATENCY-1];
        if (!tag_ill[ALU_LATENCY-1]) begin
          rsp_data_q <= alu_out;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({alu_issue, tag_out_v})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  // Clear wins over a coincident event; counters hold at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0  <= '0;
      stat_grant1  <= '0;
      stat_illegal <= '0;
    end else if (stat_clr) begin
      stat_grant0  <= '0;
      stat_grant1  <= '0;
      stat_illegal <= '0;
    end else begin
      if (xfer[0] && !(&stat_grant0)) begin
        stat_grant0 <= stat_grant0 + CNT_WIDTH'(1);
      end
      if (xfer[1] && !(&stat_grant1)) begin
        stat_grant1 <= stat_grant1 + CNT_WIDTH'(1);
      end
      if (alu_issue && alu_opcode[2] && !(&stat_illegal)) begin
        stat_illegal <= stat_illegal + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb/tb_alu_op_scheduler.sv - directed self-checking bench for alu_op_scheduler
module tb_alu_op_scheduler;
  localparam int DW = 512;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          alu_issue;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_data;
  logic [DW-1:0] alu_out;
`ifdef ALU_SCHED_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_grant0;
  logic [31:0]   stat_grant1;
  logic [31:0]   stat_illegal;
`endif

  alu_op_scheduler_if #(.DATA_WIDTH(DW)) rif ();

  alu_op_scheduler #(.DATA_WIDTH(DW), .ALU_LATENCY(L), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (rif.slave),
    .alu_issue  (alu_issue),
    .alu_opcode (alu_opcode),
    .alu_data   (alu_data),
    .alu_out    (alu_out),
    .flush_req  (flush_req),
    .flush_done (flush_done)
`ifdef ALU_SCHED_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_grant0  (stat_grant0),
    .stat_grant1  (stat_grant1),
    .stat_illegal (stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Illegal opcodes return the operand so a missing zero-force shows up.
  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] d);
    case (op)
      3'd0:    alu_fn = {{(DW-1){1'b0}}, ^d};
      3'd1:    alu_fn = DW'($countones(d));
      3'd2:    alu_fn = {d[0], d[DW-1:1]};
      3'd3:    alu_fn = {d[DW-2:0], d[DW-1]};
      default: alu_fn = d;
    endcase
  endfunction

  logic [DW-1:0] alu_pipe [L];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(alu_opcode, alu_data);
    for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_out = alu_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            g_own [$];
  int            g_cyc [$];
  int            r_own [$];
  int            r_cyc [$];
  logic [DW-1:0] r_data [$];
  logic          r_err [$];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (rif.req_valid[i] && rif.req_ready[i]) begin
          g_own.push_back(i);
          g_cyc.push_back(cyc);
        end
        if (rif.rsp_valid[i]) begin
          r_own.push_back(i);
          r_cyc.push_back(cyc);
          r_data.push_back(rif.rsp_data);
          r_err.push_back(rif.rsp_err);
        end
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    g_own.delete(); g_cyc.delete();
    r_own.delete(); r_cyc.delete(); r_data.delete(); r_err.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rif.req_valid = 2'b00;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clear_q();
  endtask

  logic [DW-1:0] rot_exp;
  int            fd_cyc;

  initial begin
    rif.req_valid   = 2'b11;
    rif.req_opcode0 = 3'd0;
    rif.req_opcode1 = 3'd0;
    rif.req_data0   = '0;
    rif.req_data1   = '0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_ready",     DW'(rif.req_ready), DW'(0));
    check("reset_issue",     DW'(alu_issue),     DW'(0));
    check("reset_opcode",    DW'(alu_opcode),    DW'(0));
    check("reset_alu_data",  alu_data,           DW'(0));
    check("reset_rsp_valid", DW'(rif.rsp_valid), DW'(0));
    check("reset_rsp_data",  rif.rsp_data,       DW'(0));
    check("reset_rsp_err",   DW'(rif.rsp_err),   DW'(0));
    check("reset_flush_done", DW'(flush_done),   DW'(0));

    // Single POPCOUNT op from requester 0
    do_reset();
    rif.req_valid = 2'b01; rif.req_opcode0 = 3'd1; rif.req_data0 = DW'(8'hFF);
    @(posedge clk); #2 rif.req_valid = 2'b00;
    repeat (8) @(posedge clk); #2;
    check("single_grants", DW'(g_own.size()), DW'(1));
    check("single_rsps",   DW'(r_own.size()), DW'(1));
    if (g_own.size() == 1 && r_own.size() == 1) begin
      check("single_owner",   DW'(r_own[0]),            DW'(0));
      check("single_data",    r_data[0],                DW'(8));
      check("single_err",     DW'(r_err[0]),            DW'(0));
      check("single_latency", DW'(r_cyc[0] - g_cyc[0]), DW'(4));
    end

    // Contention: both valid for six cycles
    do_reset();
    rif.req_opcode0 = 3'd1; rif.req_data0 = DW'(8'h0F);
    rif.req_opcode1 = 3'd2; rif.req_data1 = DW'(2'b11);
    rot_exp = '0; rot_exp[DW-1] = 1'b1; rot_exp[0] = 1'b1;
    rif.req_valid = 2'b11;
    repeat (6) @(posedge clk); #2 rif.req_valid = 2'b00;
    repeat (8) @(posedge clk); #2;
    check("cont_grants", DW'(g_own.size()), DW'(6));
    check("cont_rsps",   DW'(r_own.size()), DW'(6));
    if (g_own.size() == 6 && r_own.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("cont_gown%0d", i), DW'(g_own[i]), DW'(i % 2));
        check($sformatf("cont_gcyc%0d", i), DW'(g_cyc[i] - g_cyc[0]), DW'(i));
        check($sformatf("cont_rown%0d", i), DW'(r_own[i]), DW'(i % 2));
        check($sformatf("cont_rdat%0d", i), r_data[i], (i % 2 == 1) ? rot_exp : DW'(4));
        check($sformatf("cont_rlat%0d", i), DW'(r_cyc[i] - g_cyc[i]), DW'(4));
      end
    end

    // Illegal opcode from requester 1
    do_reset();
    rif.req_valid = 2'b10; rif.req_opcode1 = 3'd5; rif.req_data1 = '1;
    @(posedge clk); #2 rif.req_valid = 2'b00;
    repeat (8) @(posedge clk); #2;
    check("ill_rsps", DW'(r_own.size()), DW'(1));
    if (r_own.size() == 1) begin
      check("ill_owner", DW'(r_own[0]), DW'(1));
      check("ill_data",  r_data[0],     DW'(0));
      check("ill_err",   DW'(r_err[0]), DW'(1));
    end
`ifdef ALU_SCHED_STATS_EN
    check("ill_stat", DW'(stat_illegal), DW'(1));
`endif

    // Flush with two ops in flight
    do_reset();
    rif.req_valid = 2'b01; rif.req_opcode0 = 3'd0; rif.req_data0 = DW'(3'b111);
    @(posedge clk); #2;
    rif.req_valid = 2'b10; rif.req_opcode1 = 3'd3; rif.req_data1 = '0; rif.req_data1[DW-1] = 1'b1;
    @(posedge clk); #2;
    rif.req_valid = 2'b11; flush_req = 1'b1;
    #3 check("flush_ready_now", DW'(rif.req_ready), DW'(0));
    rif.req_valid = 2'b00;
    fd_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (flush_done && fd_cyc < 0) fd_cyc = cyc;
    end
    check("flush_grants", DW'(g_own.size()), DW'(2));
    check("flush_rsps",   DW'(r_own.size()), DW'(2));
    if (r_own.size() == 2) begin
      check("flush_rown0", DW'(r_own[0]), DW'(0));
      check("flush_rdat0", r_data[0],     DW'(1));
      check("flush_rown1", DW'(r_own[1]), DW'(1));
      check("flush_rdat1", r_data[1],     DW'(1));
      check("flush_done_cyc", DW'(fd_cyc - r_cyc[1]), DW'(1));
    end
    check("flush_done_hold", DW'(flush_done), DW'(1));
    @(posedge clk); #2;
    flush_req = 1'b0; rif.req_valid = 2'b01;
    @(posedge clk); #3;
    check("flush_exit_done",  DW'(flush_done),    DW'(0));
    check("flush_exit_ready", DW'(rif.req_ready), DW'(1));
    rif.req_valid = 2'b00;
    repeat (8) @(posedge clk);

    // Reset one cycle after an issue
    do_reset();
    rif.req_valid = 2'b01; rif.req_opcode0 = 3'd1; rif.req_data0 = DW'(8'hFF);
    @(posedge clk); #2 rif.req_valid = 2'b00;
    @(posedge clk); #3;
    rif.req_valid = 2'b11; rst = 1'b1;
    #1;
    check("rstmid_ready",     DW'(rif.req_ready), DW'(0));
    check("rstmid_issue",     DW'(alu_issue),     DW'(0));
    check("rstmid_rsp_valid", DW'(rif.rsp_valid), DW'(0));
    check("rstmid_rsp_data",  rif.rsp_data,       DW'(0));
    check("rstmid_rsp_err",   DW'(rif.rsp_err),   DW'(0));
    rif.req_valid = 2'b00;
    @(posedge clk); #2 rst = 1'b0;
    clear_q();
    repeat (6) @(posedge clk); #2;
    check("rstmid_no_rsp", DW'(r_own.size()), DW'(0));
    rif.req_valid = 2'b11;
    @(posedge clk); #2 rif.req_valid = 2'b00;
    check("rstmid_grants", DW'(g_own.size()), DW'(1));
    if (g_own.size() >= 1) check("rstmid_first_owner", DW'(g_own[0]), DW'(0));
    repeat (6) @(posedge clk);

`ifdef ALU_SCHED_STATS_EN
    do_reset();
    rif.req_opcode0 = 3'd1; rif.req_opcode1 = 3'd1;
    rif.req_valid = 2'b11;
    repeat (4) @(posedge clk); #2 rif.req_valid = 2'b01;
    @(posedge clk); #2 rif.req_valid = 2'b00;
    repeat (2) @(posedge clk); #2;
    check("stat_g0", DW'(stat_grant0), DW'(3));
    check("stat_g1", DW'(stat_grant1), DW'(2));
    stat_clr = 1'b1;
    @(posedge clk); #2 stat_clr = 1'b0;
    check("stat_g0_clr", DW'(stat_grant0), DW'(0));
    check("stat_g1_clr", DW'(stat_grant1), DW'(0));
    repeat (6) @(posedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
